bird_physics: RTL

Fixed-point vertical physics engine for the player bird: a parametrised successor to the team's fixed-constant velocity block. It adds signed velocity with terminal-speed saturation, position integration, and floor/ceiling handling. It also owns a game-state FSM (IDLE/FLY/DEAD), a built-in tick generator, and edge-detected flap input. It feeds the renderer (position) and the collision/score logic (crashed, alive).

---
 rtl/bird_physics_if.sv | 28 ++
 rtl/bird_physics.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bird_physics_if.sv
// Bundles the control inputs and physics/state outputs of bird_physics.
//   start, button, pause       : game controls driven by the master side
//   velocity, position         : fixed-point physics state (signed / unsigned)
//   tick, alive, crashed       : update strobe and game-state flags
// The master modport is the game/bench side; the slave modport is the engine.
interface bird_physics_if #(
    parameter int VEL_W = 10,
    parameter int POS_W = 10
) ();
    logic                    start;
    logic                    button;
    logic                    pause;
    logic signed [VEL_W-1:0] velocity;
    logic        [POS_W-1:0] position;
    logic                    tick;
    logic                    alive;
    logic                    crashed;

    modport master (
        output start, button, pause,
        input  velocity, position, tick, alive, crashed
    );

    modport slave (
        input  start, button, pause,
        output velocity, position, tick, alive, crashed
    );
endinterface

// File: rtl/bird_physics.sv
// Fixed-point vertical physics engine for the player bird.
// Owns the IDLE/FLY/DEAD game FSM, a free-running physics tick generator,
// rising-edge flap detection, gravity with terminal-speed saturation and
// position integration with floor (fatal) and ceiling (clamped) limits.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : bird_physics_if.slave
//            start   - pulse; IDLE->FLY, DEAD->IDLE, ignored in FLY
//            button  - flap request level (already synchronised)
//            pause   - level; freezes physics in FLY
//            velocity, position - registered physics state
//            tick    - one-cycle strobe following each applied update
//            alive / crashed - registered FLY / DEAD flags
module bird_physics #(
    parameter int VEL_W       = 10,
    parameter int POS_W       = 10,
    parameter int TICK_CYCLES = 500000,
    parameter int FLAP_VEL    = 40,
    parameter int GRAVITY     = 10,
    parameter int MAX_FALL    = 120,
    parameter int POS_START   = 240,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 479
) (
    input logic           clk,
    input logic           rst_n,
    bird_physics_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FLY  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam int VW1   = VEL_W + 1;
    localparam int PW2   = POS_W + 2;
    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    // Velocity arithmetic runs one bit wider so v - GRAVITY can never wrap
    // before the terminal-speed clamp sees it.
    localparam logic signed [VEL_W:0] FLAP_X = VW1'(FLAP_VEL);
    localparam logic signed [VEL_W:0] GRAV_X = VW1'(GRAVITY);
    localparam logic signed [VEL_W:0] MAXF_X = VW1'(-MAX_FALL);

    // Position sum carries a sign bit plus one overflow bit over POS_W.
    localparam logic signed [PW2-1:0] PMIN_X = PW2'(POS_MIN);
    localparam logic signed [PW2-1:0] PMAX_X = PW2'(POS_MAX);

    localparam logic [POS_W-1:0] PSTART_P = POS_W'(POS_START);
    localparam logic [POS_W-1:0] PMIN_P   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] PMAX_P   = POS_W'(POS_MAX);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    flap_q, flap_d;
    logic                    button_q;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic                    tick_q, tick_d;
    logic                    alive_q, crashed_q;

    logic                    rise;
    logic signed [VEL_W:0]   v_ext;
    logic signed [VEL_W:0]   v_dec;
    logic signed [VEL_W:0]   v_sat;
    logic signed [VEL_W:0]   v_new;
    logic signed [PW2-1:0]   p_sum;

    // Candidate values for the next tick; only committed on a counter wrap.
    always_comb begin
        rise  = bus.button & ~button_q;
        v_ext = VW1'(vel_q);
        v_dec = v_ext - GRAV_X;
        v_sat = (v_dec < MAXF_X) ? MAXF_X : v_dec;
        v_new = flap_q ? FLAP_X : v_sat;
        // Integration uses the velocity held before this tick's update.
        p_sum = $signed({2'b00, pos_q}) + PW2'(vel_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flap_d  = flap_q;
        vel_d   = vel_q;
        pos_d   = pos_q;
        tick_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pos_d  = PSTART_P;
                vel_d  = '0;
                flap_d = 1'b0;
                cnt_d  = '0;
                if (bus.start) begin
                    state_d = ST_FLY;
                end
            end

            ST_FLY: begin
                // start is deliberately not decoded here, so a start that
                // lands on a tick cannot disturb the update.
                if (!bus.pause) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        // An edge in the tick cycle itself belongs to the
                        // next tick rather than being merged into this one.
                        flap_d = rise;
                        if (p_sum <= PMIN_X) begin
                            pos_d   = PMIN_P;
                            vel_d   = '0;
                            state_d = ST_DEAD;
                        end else if (p_sum > PMAX_X) begin
                            // Ceiling wins over a pending flap.
                            pos_d = PMAX_P;
                            vel_d = '0;
                        end else begin
                            pos_d = POS_W'(p_sum);
                            vel_d = VEL_W'(v_new);
                        end
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        flap_d = flap_q | rise;
                    end
                end
            end

            ST_DEAD: begin
                flap_d = 1'b0;
                cnt_d  = '0;
                if (bus.start) begin
                    state_d = ST_IDLE;
                    pos_d   = PSTART_P;
                    vel_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                flap_d  = 1'b0;
                cnt_d   = '0;
                pos_d   = PSTART_P;
                vel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            flap_q    <= 1'b0;
            button_q  <= 1'b0;
            vel_q     <= '0;
            pos_q     <= PSTART_P;
            tick_q    <= 1'b0;
            alive_q   <= 1'b0;
            crashed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flap_q    <= flap_d;
            // History tracks the button in every state so a level held
            // across a pause or restart never looks like a fresh edge.
            button_q  <= bus.button;
            vel_q     <= vel_d;
            pos_q     <= pos_d;
            tick_q    <= tick_d;
            alive_q   <= (state_d == ST_FLY);
            crashed_q <= (state_d == ST_DEAD);
        end
    end

    assign bus.velocity = vel_q;
    assign bus.position = pos_q;
    assign bus.tick     = tick_q;
    assign bus.alive    = alive_q;
    assign bus.crashed  = crashed_q;

endmodule
